// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer: issues TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto
// the TLB ports one command at a time, returns a single-cycle result pulse
// to the CSR unit and keeps the TLBFILL round-robin pointer.
module tlb_op_ctrl #(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [4:0]      cmd_invop,
  input  logic [9:0]      cmd_asid,
  input  logic [18:0]     cmd_vppn,
  input  logic [18:0]     csr_vppn,
  input  logic [IDXW-1:0] csr_index,
  input  logic [5:0]      csr_ps,
  input  logic            csr_ne,
  input  logic [9:0]      csr_asid,
  input  logic [26:0]     csr_elo0,
  input  logic [26:0]     csr_elo1,
  input  logic [18:0]     mem_s1_vppn,
  input  logic [9:0]      mem_s1_asid,
  output logic            mem_stall,
  output logic [18:0]     tlb_s1_vppn,
  output logic [9:0]      tlb_s1_asid,
  input  logic            tlb_s1_found,
  input  logic [IDXW-1:0] tlb_s1_index,
  output logic            tlb_invtlb_valid,
  output logic [4:0]      tlb_invtlb_op,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic            tlb_w_e,
  output logic [18:0]     tlb_w_vppn,
  output logic [5:0]      tlb_w_ps,
  output logic [9:0]      tlb_w_asid,
  output logic            tlb_w_g,
  output logic [26:0]     tlb_w_elo0,
  output logic [26:0]     tlb_w_elo1,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic            tlb_r_e,
  input  logic [18:0]     tlb_r_vppn,
  input  logic [5:0]      tlb_r_ps,
  input  logic [9:0]      tlb_r_asid,
  input  logic [26:0]     tlb_r_elo0,
  input  logic [26:0]     tlb_r_elo1,
  output logic            res_valid,
  output logic [2:0]      res_op,
  output logic            res_ne,
  output logic [IDXW-1:0] res_index,
  output logic [18:0]     res_vppn,
  output logic [5:0]      res_ps,
  output logic [9:0]      res_asid,
  output logic [26:0]     res_elo0,
  output logic [26:0]     res_elo1,
  output logic            res_err
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  // ELO packing {ppn[19:0], g, mat[1:0], plv[1:0], d, v}: G is bit 6
  localparam int unsigned ELO_G = 6;

  localparam logic [IDXW-1:0] FILL_LAST = IDXW'(TLBNUM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SRCH, S_RD, S_WR, S_INV, S_DONE
  } state_t;

  state_t          state_q;
  logic [IDXW-1:0] fill_ptr_q;

  // Command and CSR snapshot taken at accept
  logic [2:0]      op_q;
  logic [4:0]      invop_q;
  logic [9:0]      cmd_asid_q;
  logic [18:0]     cmd_vppn_q;
  logic [18:0]     vppn_q;
  logic [IDXW-1:0] index_q;
  logic [5:0]      ps_q;
  logic            ne_q;
  logic [9:0]      asid_q;
  logic [26:0]     elo0_q;
  logic [26:0]     elo1_q;

  logic            we_q;
  logic            inv_q;

  logic            res_valid_q;
  logic [2:0]      res_op_q;
  logic            res_ne_q;
  logic [IDXW-1:0] res_index_q;
  logic [18:0]     res_vppn_q;
  logic [5:0]      res_ps_q;
  logic [9:0]      res_asid_q;
  logic [26:0]     res_elo0_q;
  logic [26:0]     res_elo1_q;
  logic            res_err_q;

  logic [IDXW-1:0] fill_ptr_d;

  // Round-robin fill pointer successor, wraps at TLBNUM-1
  always_comb begin
    fill_ptr_d = fill_ptr_q + 1'b1;
    if (fill_ptr_q == FILL_LAST) fill_ptr_d = '0;
  end

  // Control FSM: command accept, per-op single cycle, result pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      fill_ptr_q  <= '0;
      op_q        <= '0;
      invop_q     <= '0;
      cmd_asid_q  <= '0;
      cmd_vppn_q  <= '0;
      vppn_q      <= '0;
      index_q     <= '0;
      ps_q        <= '0;
      ne_q        <= 1'b0;
      asid_q      <= '0;
      elo0_q      <= '0;
      elo1_q      <= '0;
      we_q        <= 1'b0;
      inv_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_op_q    <= '0;
      res_ne_q    <= 1'b0;
      res_index_q <= '0;
      res_vppn_q  <= '0;
      res_ps_q    <= '0;
      res_asid_q  <= '0;
      res_elo0_q  <= '0;
      res_elo1_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      we_q        <= 1'b0;
      inv_q       <= 1'b0;
      res_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q       <= cmd_op;
            invop_q    <= cmd_invop;
            cmd_asid_q <= cmd_asid;
            cmd_vppn_q <= cmd_vppn;
            vppn_q     <= csr_vppn;
            index_q    <= csr_index;
            ps_q       <= csr_ps;
            ne_q       <= csr_ne;
            asid_q     <= csr_asid;
            elo0_q     <= csr_elo0;
            elo1_q     <= csr_elo1;
            res_err_q  <= 1'b0;
            case (cmd_op)
              OP_SRCH: state_q <= S_SRCH;
              OP_RD:   state_q <= S_RD;
              OP_WR, OP_FILL: begin
                state_q <= S_WR;
                we_q    <= 1'b1;
              end
              OP_INV: begin
                state_q <= S_INV;
                inv_q   <= (cmd_invop <= 5'd6);
              end
              default: begin
                // Illegal op: no TLB access, result pulse on the next cycle
                state_q     <= S_DONE;
                res_valid_q <= 1'b1;
                res_op_q    <= cmd_op;
                res_err_q   <= 1'b1;
              end
            endcase
          end
        end
        S_SRCH: begin
          res_ne_q    <= ~tlb_s1_found;
          res_index_q <= tlb_s1_found ? tlb_s1_index : '0;
          res_op_q    <= op_q;
          res_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_RD: begin
          res_ne_q    <= ~tlb_r_e;
          res_vppn_q  <= tlb_r_e ? tlb_r_vppn : '0;
          res_ps_q    <= tlb_r_e ? tlb_r_ps   : '0;
          res_asid_q  <= tlb_r_e ? tlb_r_asid : '0;
          res_elo0_q  <= tlb_r_e ? tlb_r_elo0 : '0;
          res_elo1_q  <= tlb_r_e ? tlb_r_elo1 : '0;
          res_op_q    <= op_q;
          res_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_WR: begin
          if (op_q == OP_FILL) fill_ptr_q <= fill_ptr_d;
          res_op_q    <= op_q;
          res_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_INV: begin
          if (invop_q > 5'd6) res_err_q <= 1'b1;
          res_op_q    <= op_q;
          res_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Port 1 is borrowed from the load/store path during search and invalidate
  always_comb begin
    mem_stall   = 1'b0;
    tlb_s1_vppn = mem_s1_vppn;
    tlb_s1_asid = mem_s1_asid;
    if (state_q == S_SRCH) begin
      mem_stall   = 1'b1;
      tlb_s1_vppn = vppn_q;
      tlb_s1_asid = asid_q;
    end else if (state_q == S_INV) begin
      mem_stall   = 1'b1;
      tlb_s1_vppn = cmd_vppn_q;
      tlb_s1_asid = cmd_asid_q;
    end
  end

  assign cmd_ready        = (state_q == S_IDLE);
  assign tlb_invtlb_valid = inv_q;
  assign tlb_invtlb_op    = invop_q;
  assign tlb_we           = we_q;
  assign tlb_w_index      = (op_q == OP_FILL) ? fill_ptr_q : index_q;
  assign tlb_w_e          = ~ne_q;
  assign tlb_w_vppn       = vppn_q;
  assign tlb_w_ps         = ps_q;
  assign tlb_w_asid       = asid_q;
  assign tlb_w_g          = elo0_q[ELO_G] & elo1_q[ELO_G];
  assign tlb_w_elo0       = elo0_q;
  assign tlb_w_elo1       = elo1_q;
  assign tlb_r_index      = index_q;

  assign res_valid = res_valid_q;
  assign res_op    = res_op_q;
  assign res_ne    = res_ne_q;
  assign res_index = res_index_q;
  assign res_vppn  = res_vppn_q;
  assign res_ps    = res_ps_q;
  assign res_asid  = res_asid_q;
  assign res_elo0  = res_elo0_q;
  assign res_elo1  = res_elo1_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl: vector table plus fill-pointer and
// mid-operation reset sequences.
module tb_tlb_op_ctrl;

  localparam logic [18:0] MEM_VPPN = 19'h55555;
  localparam logic [9:0]  MEM_ASID = 10'h1CC;
  localparam logic [9:0]  CSR_ASID = 10'h2A5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_invop;
  logic [9:0]  cmd_asid;
  logic [18:0] cmd_vppn, csr_vppn;
  logic [3:0]  csr_index;
  logic [5:0]  csr_ps;
  logic        csr_ne;
  logic [9:0]  csr_asid;
  logic [26:0] csr_elo0, csr_elo1;
  logic [18:0] mem_s1_vppn;
  logic [9:0]  mem_s1_asid;
  logic        mem_stall;
  logic [18:0] tlb_s1_vppn;
  logic [9:0]  tlb_s1_asid;
  logic        tlb_s1_found;
  logic [3:0]  tlb_s1_index;
  logic        tlb_invtlb_valid;
  logic [4:0]  tlb_invtlb_op;
  logic        tlb_we;
  logic [3:0]  tlb_w_index;
  logic        tlb_w_e;
  logic [18:0] tlb_w_vppn;
  logic [5:0]  tlb_w_ps;
  logic [9:0]  tlb_w_asid;
  logic        tlb_w_g;
  logic [26:0] tlb_w_elo0, tlb_w_elo1;
  logic [3:0]  tlb_r_index;
  logic        tlb_r_e;
  logic [18:0] tlb_r_vppn;
  logic [5:0]  tlb_r_ps;
  logic [9:0]  tlb_r_asid;
  logic [26:0] tlb_r_elo0, tlb_r_elo1;
  logic        res_valid;
  logic [2:0]  res_op;
  logic        res_ne;
  logic [3:0]  res_index;
  logic [18:0] res_vppn;
  logic [5:0]  res_ps;
  logic [9:0]  res_asid;
  logic [26:0] res_elo0, res_elo1;
  logic        res_err;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLBNUM(16)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_invop(cmd_invop), .cmd_asid(cmd_asid), .cmd_vppn(cmd_vppn),
    .csr_vppn(csr_vppn), .csr_index(csr_index), .csr_ps(csr_ps),
    .csr_ne(csr_ne), .csr_asid(csr_asid), .csr_elo0(csr_elo0),
    .csr_elo1(csr_elo1), .mem_s1_vppn(mem_s1_vppn), .mem_s1_asid(mem_s1_asid),
    .mem_stall(mem_stall), .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_asid(tlb_s1_asid),
    .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
    .tlb_invtlb_valid(tlb_invtlb_valid), .tlb_invtlb_op(tlb_invtlb_op),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e),
    .tlb_w_vppn(tlb_w_vppn), .tlb_w_ps(tlb_w_ps), .tlb_w_asid(tlb_w_asid),
    .tlb_w_g(tlb_w_g), .tlb_w_elo0(tlb_w_elo0), .tlb_w_elo1(tlb_w_elo1),
    .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_vppn(tlb_r_vppn),
    .tlb_r_ps(tlb_r_ps), .tlb_r_asid(tlb_r_asid), .tlb_r_elo0(tlb_r_elo0),
    .tlb_r_elo1(tlb_r_elo1), .res_valid(res_valid), .res_op(res_op),
    .res_ne(res_ne), .res_index(res_index), .res_vppn(res_vppn),
    .res_ps(res_ps), .res_asid(res_asid), .res_elo0(res_elo0),
    .res_elo1(res_elo1), .res_err(res_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  invop;
    logic [9:0]  cmd_asid;
    logic [18:0] cmd_vppn;
    logic [18:0] csr_vppn;
    logic [3:0]  csr_index;
    logic        csr_ne;
    logic [26:0] elo0;
    logic [26:0] elo1;
    logic        found;
    logic [3:0]  s1_idx;
    logic        r_e;
    // expectations
    logic        x_ill;
    logic        x_we;
    logic [3:0]  x_widx;
    logic        x_e;
    logic        x_g;
    logic        x_stall;
    logic [18:0] x_s1_vppn;
    logic [9:0]  x_s1_asid;
    logic        x_inv;
    logic        x_err;
    logic        x_chk_s;
    logic        x_chk_r;
    logic        x_ne;
    logic [3:0]  x_idx;
    logic [18:0] x_rvppn;
    logic [26:0] x_relo0;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t base(input logic [2:0] op);
    vec_t v;
    v = '{default: '0};
    v.op        = op;
    v.x_s1_vppn = MEM_VPPN;
    v.x_s1_asid = MEM_ASID;
    return v;
  endfunction

  task automatic run_op(input vec_t v, input string nm);
    @(negedge clk);
    chk({nm, ".ready"}, 32'(cmd_ready), 32'd1);
    cmd_op = v.op; cmd_invop = v.invop; cmd_asid = v.cmd_asid; cmd_vppn = v.cmd_vppn;
    csr_vppn = v.csr_vppn; csr_index = v.csr_index; csr_ne = v.csr_ne;
    csr_elo0 = v.elo0; csr_elo1 = v.elo1;
    tlb_s1_found = v.found; tlb_s1_index = v.s1_idx; tlb_r_e = v.r_e;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (v.x_ill) begin
      chk({nm, ".we"}, 32'(tlb_we), 32'd0);
      chk({nm, ".inv"}, 32'(tlb_invtlb_valid), 32'd0);
      chk({nm, ".stall"}, 32'(mem_stall), 32'd0);
      chk({nm, ".res_valid"}, 32'(res_valid), 32'd1);
      chk({nm, ".res_err"}, 32'(res_err), 32'd1);
      chk({nm, ".res_op"}, 32'(res_op), 32'(v.op));
    end else begin
      chk({nm, ".we"}, 32'(tlb_we), 32'(v.x_we));
      if (v.x_we) begin
        chk({nm, ".w_index"}, 32'(tlb_w_index), 32'(v.x_widx));
        chk({nm, ".w_e"}, 32'(tlb_w_e), 32'(v.x_e));
        chk({nm, ".w_g"}, 32'(tlb_w_g), 32'(v.x_g));
        chk({nm, ".w_vppn"}, 32'(tlb_w_vppn), 32'(v.csr_vppn));
        chk({nm, ".w_asid"}, 32'(tlb_w_asid), 32'(CSR_ASID));
      end
      chk({nm, ".stall"}, 32'(mem_stall), 32'(v.x_stall));
      chk({nm, ".s1_vppn"}, 32'(tlb_s1_vppn), 32'(v.x_s1_vppn));
      chk({nm, ".s1_asid"}, 32'(tlb_s1_asid), 32'(v.x_s1_asid));
      chk({nm, ".inv"}, 32'(tlb_invtlb_valid), 32'(v.x_inv));
      if (v.x_inv) chk({nm, ".inv_op"}, 32'(tlb_invtlb_op), 32'(v.invop));
      if (v.op == 3'd1) chk({nm, ".r_index"}, 32'(tlb_r_index), 32'(v.csr_index));
      chk({nm, ".early_valid"}, 32'(res_valid), 32'd0);
      @(negedge clk);
      chk({nm, ".res_valid"}, 32'(res_valid), 32'd1);
      chk({nm, ".res_op"}, 32'(res_op), 32'(v.op));
      chk({nm, ".res_err"}, 32'(res_err), 32'(v.x_err));
      chk({nm, ".we_off"}, 32'(tlb_we), 32'd0);
      chk({nm, ".stall_off"}, 32'(mem_stall), 32'd0);
      if (v.x_chk_s || v.x_chk_r) chk({nm, ".res_ne"}, 32'(res_ne), 32'(v.x_ne));
      if (v.x_chk_s) chk({nm, ".res_index"}, 32'(res_index), 32'(v.x_idx));
      if (v.x_chk_r) begin
        chk({nm, ".res_vppn"}, 32'(res_vppn), 32'(v.x_rvppn));
        chk({nm, ".res_elo0"}, 32'(res_elo0), 32'(v.x_relo0));
      end
    end
    @(negedge clk);
    chk({nm, ".pulse_end"}, 32'(res_valid), 32'd0);
    chk({nm, ".ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  vec_t vt[10];

  initial begin
    // constant environment
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_invop = '0; cmd_asid = '0;
    cmd_vppn = '0; csr_vppn = '0; csr_index = '0; csr_ps = 6'd12; csr_ne = 1'b0;
    csr_asid = CSR_ASID; csr_elo0 = '0; csr_elo1 = '0;
    mem_s1_vppn = MEM_VPPN; mem_s1_asid = MEM_ASID;
    tlb_s1_found = 1'b0; tlb_s1_index = '0; tlb_r_e = 1'b0;
    tlb_r_vppn = 19'h6ABCD; tlb_r_ps = 6'd21; tlb_r_asid = 10'h0F0;
    tlb_r_elo0 = 27'h1234567; tlb_r_elo1 = 27'h7654321;

    // WR, elo0.g=1 elo1.g=0
    vt[0] = base(3'd2); vt[0].csr_index = 4'd5; vt[0].csr_vppn = 19'h12345;
    vt[0].elo0 = 27'h40; vt[0].elo1 = 27'h0;
    vt[0].x_we = 1; vt[0].x_widx = 4'd5; vt[0].x_e = 1; vt[0].x_g = 0;
    // SRCH hit at 9
    vt[1] = base(3'd0); vt[1].csr_vppn = 19'h0ABCD; vt[1].found = 1; vt[1].s1_idx = 4'd9;
    vt[1].x_stall = 1; vt[1].x_s1_vppn = 19'h0ABCD; vt[1].x_s1_asid = CSR_ASID;
    vt[1].x_chk_s = 1; vt[1].x_ne = 0; vt[1].x_idx = 4'd9;
    // SRCH miss, index lines carry junk
    vt[2] = base(3'd0); vt[2].csr_vppn = 19'h00321; vt[2].found = 0; vt[2].s1_idx = 4'd7;
    vt[2].x_stall = 1; vt[2].x_s1_vppn = 19'h00321; vt[2].x_s1_asid = CSR_ASID;
    vt[2].x_chk_s = 1; vt[2].x_ne = 1; vt[2].x_idx = 4'd0;
    // RD 3, entry invalid
    vt[3] = base(3'd1); vt[3].csr_index = 4'd3; vt[3].r_e = 0;
    vt[3].x_chk_r = 1; vt[3].x_ne = 1; vt[3].x_rvppn = '0; vt[3].x_relo0 = '0;
    // RD 3, entry valid
    vt[4] = base(3'd1); vt[4].csr_index = 4'd3; vt[4].r_e = 1;
    vt[4].x_chk_r = 1; vt[4].x_ne = 0; vt[4].x_rvppn = 19'h6ABCD; vt[4].x_relo0 = 27'h1234567;
    // INV op 5
    vt[5] = base(3'd4); vt[5].invop = 5'd5; vt[5].cmd_asid = 10'h3; vt[5].cmd_vppn = 19'h7;
    vt[5].x_stall = 1; vt[5].x_s1_vppn = 19'h7; vt[5].x_s1_asid = 10'h3; vt[5].x_inv = 1;
    // INV op 9 is illegal
    vt[6] = base(3'd4); vt[6].invop = 5'd9; vt[6].cmd_asid = 10'h22; vt[6].cmd_vppn = 19'h11;
    vt[6].x_stall = 1; vt[6].x_s1_vppn = 19'h11; vt[6].x_s1_asid = 10'h22; vt[6].x_err = 1;
    // illegal op 6
    vt[7] = base(3'd6); vt[7].x_ill = 1;
    // WR with NE=1 at last index, both G set
    vt[8] = base(3'd2); vt[8].csr_index = 4'd15; vt[8].csr_ne = 1; vt[8].csr_vppn = 19'h7FFFF;
    vt[8].elo0 = 27'h40; vt[8].elo1 = 27'h7FFFFFF;
    vt[8].x_we = 1; vt[8].x_widx = 4'd15; vt[8].x_e = 0; vt[8].x_g = 1;
    // FILL after 17 fills: pointer sits at 1, unaffected by WR
    vt[9] = base(3'd3); vt[9].csr_index = 4'd12; vt[9].csr_vppn = 19'h2468;
    vt[9].x_we = 1; vt[9].x_widx = 4'd1; vt[9].x_e = 1; vt[9].x_g = 0;

    repeat (3) @(negedge clk);
    chk("reset.ready", 32'(cmd_ready), 32'd1);
    chk("reset.res_valid", 32'(res_valid), 32'd0);
    chk("reset.we", 32'(tlb_we), 32'd0);
    chk("reset.inv", 32'(tlb_invtlb_valid), 32'd0);
    chk("reset.stall", 32'(mem_stall), 32'd0);
    chk("reset.res_err", 32'(res_err), 32'd0);
    chk("reset.res_index", 32'(res_index), 32'd0);
    chk("reset.res_elo1", 32'(res_elo1), 32'd0);
    chk("reset.s1_vppn", 32'(tlb_s1_vppn), 32'(MEM_VPPN));
    rstn = 1'b1;

    // 17 fills: pointer walks 0..15 and wraps to 0
    for (int i = 0; i < 17; i++) begin
      vec_t f;
      f = base(3'd3);
      f.csr_index = 4'hA;
      f.csr_vppn = 19'(i);
      f.x_we = 1; f.x_widx = 4'(i % 16); f.x_e = 1; f.x_g = 0;
      run_op(f, $sformatf("fill%0d", i));
    end

    for (int i = 0; i < 10; i++) run_op(vt[i], $sformatf("vec%0d", i));

    // Reset while in the WR state: no result, pointer back to 0
    @(negedge clk);
    cmd_op = 3'd2; csr_index = 4'd7; csr_ne = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rstwr.we_before", 32'(tlb_we), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("rstwr.we_cleared", 32'(tlb_we), 32'd0);
    chk("rstwr.no_result", 32'(res_valid), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rstwr.ready", 32'(cmd_ready), 32'd1);
    chk("rstwr.still_no_result", 32'(res_valid), 32'd0);
    begin
      vec_t f;
      f = base(3'd3);
      f.csr_index = 4'd9;
      f.x_we = 1; f.x_widx = 4'd0; f.x_e = 1; f.x_g = 0;
      run_op(f, "fill_after_rst");
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Sequences TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) onto the 16-entry TLB's search, read, write and invalidate ports.
- Takes one command at a time from the EX-stage through a valid/ready handshake. Returns a one-cycle result to the CSR unit.
- Owns TLB search port 1 while a search or invalidate is in flight. During those states it stalls the load/store path that normally uses that port.
- Keeps the TLBFILL round-robin replacement pointer.

Parameters:
- TLBNUM, 16, number of TLB entries.
- IDXW, $clog2(TLBNUM), index width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller idle, command accepted when cmd_valid&&cmd_ready.
- cmd_op  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 illegal.
- cmd_invop  in  5  INVTLB op field.
- cmd_asid  in  10  INVTLB rj asid.
- cmd_vppn  in  19  INVTLB rk va[31:13].
- csr_vppn  in  19  TLBEHI.VPPN.
- csr_index  in  IDXW  TLBIDX.Index.
- csr_ps  in  6  TLBIDX.PS.
- csr_ne  in  1  TLBIDX.NE.
- csr_asid  in  10  ASID.ASID.
- csr_elo0  in  27  {ppn[19:0],g,mat[1:0],plv[1:0],d,v}.
- csr_elo1  in  27  same packing.
- mem_s1_vppn  in  19  load/store search vppn.
- mem_s1_asid  in  10  load/store search asid.
- mem_stall  out  1  port 1 taken, hold memory stage.
- tlb_s1_vppn  out  19  to TLB port 1.
- tlb_s1_asid  out  10  to TLB port 1.
- tlb_s1_found  in  1  TLB port 1 hit.
- tlb_s1_index  in  IDXW  TLB port 1 hit index.
- tlb_invtlb_valid  out  1  invalidate strobe.
- tlb_invtlb_op  out  5  invalidate op.
- tlb_we  out  1  write strobe.
- tlb_w_index  out  IDXW  write index.
- tlb_w_e  out  1  write E bit.
- tlb_w_vppn  out  19  write VPPN.
- tlb_w_ps  out  6  write PS.
- tlb_w_asid  out  10  write ASID.
- tlb_w_g  out  1  write G bit.
- tlb_w_elo0  out  27  write ELO0, packed as csr_elo0.
- tlb_w_elo1  out  27  write ELO1, packed as csr_elo1.
- tlb_r_index  out  IDXW  read index.
- tlb_r_e  in  1  read E.
- tlb_r_vppn  in  19  read VPPN.
- tlb_r_ps  in  6  read PS.
- tlb_r_asid  in  10  read ASID.
- tlb_r_elo0  in  27  read ELO0.
- tlb_r_elo1  in  27  read ELO1.
- res_valid  out  1  one-cycle result pulse.
- res_op  out  3  op that completed.
- res_ne  out  1  result NE.
- res_index  out  IDXW  result index.
- res_vppn  out  19  result VPPN.
- res_ps  out  6  result PS.
- res_asid  out  10  result ASID.
- res_elo0  out  27  result ELO0.
- res_elo1  out  27  result ELO1.
- res_err  out  1  illegal op/invop, raise INE.

Behaviour:
- Reset: rstn synchronous, active-low; clock clk; rising edge. On reset:
  - state=IDLE, fill_ptr=0.
  - All res_* outputs 0, tlb_we=0, tlb_invtlb_valid=0, mem_stall=0.
  - Reset mid-operation aborts the op with no write and no result.
- States: IDLE, SRCH, RD, WR, INV, DONE.
- cmd_ready=1 only in IDLE. On accept (cycle T):
  - Latch cmd_* and all csr_* inputs.
  - Go to SRCH, RD, WR (ops 2 and 3) or INV.
  - cmd_op 5-7 goes straight to DONE with res_err=1 and no TLB access.
- Each op state lasts exactly one cycle, then DONE. res_valid=1 in DONE (T+2), then IDLE. Next accept is possible at T+3.
- SRCH:
  - tlb_s1_vppn=latched csr_vppn, tlb_s1_asid=latched csr_asid; mem_stall=1.
  - Capture res_ne=~tlb_s1_found and res_index=found?tlb_s1_index:0.
- RD:
  - tlb_r_index=latched csr_index.
  - If tlb_r_e=1: res_ne=0, res_vppn/ps/asid/elo0/elo1 = tlb_r_*.
  - If tlb_r_e=0: res_ne=1 and all other fields 0.
- WR/FILL: tlb_we=1 for one cycle with the following write fields.
  - tlb_w_index = csr_index for WR, fill_ptr for FILL.
  - tlb_w_e = ~csr_ne.
  - tlb_w_vppn = csr_vppn, tlb_w_ps = csr_ps, tlb_w_asid = csr_asid.
  - tlb_w_g = elo0.g & elo1.g.
  - tlb_w_elo0/elo1 = csr values.
  - FILL increments fill_ptr modulo TLBNUM (TLBNUM-1 wraps to 0) in the same cycle. No other event changes fill_ptr.
- INV:
  - tlb_s1_vppn=cmd_vppn, tlb_s1_asid=cmd_asid, mem_stall=1.
  - cmd_invop<=6: tlb_invtlb_valid=1 for one cycle, tlb_invtlb_op=cmd_invop.
  - cmd_invop>6: no strobe, res_err=1.
- Outside SRCH/INV: tlb_s1_vppn/asid pass mem_s1_vppn/asid combinationally, mem_stall=0.
- Outside the result pulse, res_* hold their last values; res_err clears at next accept.
- res_op = latched cmd_op.
- cmd_valid in a non-IDLE state is ignored, i.e. not accepted.

Test Plan:
- Reset, then cmd_valid FILL x17 with csr_ne=0 -> tlb_w_index 0..15 then 0; tlb_w_e=1 each; res_valid 2 cycles after each accept.
- WR csr_index=5, csr_vppn=0x12345, elo0.g=1, elo1.g=0 -> tlb_we one cycle, w_index=5, w_g=0.
- SRCH with TLB hit at entry 9 -> mem_stall=1 for exactly one cycle, tlb_s1_vppn=csr_vppn, res_ne=0, res_index=9.
- SRCH miss -> res_ne=1, res_index=0.
- RD index 3 with tlb_r_e=0 -> res_ne=1, res_vppn=0, res_elo0=0.
- RD index 3 with tlb_r_e=1 -> tlb_r fields copied to res_*.
- INV invop=5, asid=0x3, vppn=0x7 -> tlb_invtlb_valid one cycle, op=5, port 1 driven with 0x7/0x3.
- INV invop=9 -> no strobe, res_err=1.
- Cmd_op=6 -> res_err=1, no TLB access.
- Rstn low during WR state -> tlb_we=0 next cycle, state IDLE, cmd_ready=1 after release.
